fifo_rr_scheduler: RTL and testbench

//  Round-robin drain scheduler for NUM_SRC first-word-fall-through FIFOs feeding one valid/ready stream.

---
 rtl/fifo_sched_pkg.sv | 11 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_rr_scheduler.sv | 87 ++++++++
 tb/tb_fifo_rr_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared state type and index-width helper for the FIFO round-robin scheduler.
package fifo_sched_pkg;

   typedef enum logic {S_IDLE, S_BURST} sched_state_t;

   // Index width that stays at least one bit even for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set request after last_ptr, wrapping modulo N.
module rr_pick
   import fifo_sched_pkg::*;
#(
   parameter int  N = 4,
   localparam int W = idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_ptr,
   output logic [W-1:0] pick,
   output logic         any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;

   always_comb begin
      int start;
      int off;
      start = (int'(last_ptr) + 1) % N;
      dbl   = {req, req};
      rot   = dbl[start +: N];
      off   = 0;
      for (int i = N - 1; i >= 0; i--) off = rot[i] ? i : off;
      any   = |req;
      pick  = W'((start + off) % N);
   end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: drains a bank of FWFT FIFOs round-robin into one valid/ready stream,
// at most MAX_BURST words per grant with one arbitration cycle before every burst.
module fifo_rr_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int  NUM_SRC   = 4,
   parameter int  WIDTH     = 32,
   parameter int  MAX_BURST = 8,
   localparam int SW        = idx_w(NUM_SRC),
   localparam int BW        = idx_w(MAX_BURST)
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic [NUM_SRC-1:0]       src_en,
   input  logic [NUM_SRC-1:0]       src_empty,
   input  logic [NUM_SRC*WIDTH-1:0] src_dout,
   output logic [NUM_SRC-1:0]       src_rd_en,
   output logic [WIDTH-1:0]         m_data,
   output logic [SW-1:0]            m_src,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic                     busy
);

   sched_state_t        state, state_nxt;
   logic [SW-1:0]       grant, grant_nxt, last_ptr, last_ptr_nxt, pick, sel;
   logic [BW-1:0]       beat_cnt, beat_nxt;
   logic [NUM_SRC-1:0]  req;
   logic                any, in_burst, xfer, at_last;

   assign req = src_en & ~src_empty;

   rr_pick #(.N(NUM_SRC)) u_pick (
      .req      (req),
      .last_ptr (last_ptr),
      .pick     (pick),
      .any      (any)
   );

   // Outputs are gated by srst in the same cycle so no pop can escape during reset.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      last_ptr_nxt = last_ptr;
      beat_nxt     = beat_cnt;
      sel          = srst ? '0 : grant;
      in_burst     = !srst && state == S_BURST;
      at_last      = beat_cnt == BW'(MAX_BURST - 1);
      m_data       = src_dout[int'(sel)*WIDTH +: WIDTH];
      m_src        = sel;
      m_valid      = in_burst && !src_empty[grant];
      xfer         = m_valid && m_ready;
      m_last       = m_valid && at_last;
      busy         = in_burst;
      src_rd_en    = '0;
      src_rd_en[grant] = xfer;
      if (state == S_IDLE) begin
         if (any) begin
            grant_nxt    = pick;
            last_ptr_nxt = pick;
            beat_nxt     = '0;
            state_nxt    = S_BURST;
         end
      end else if (xfer) begin
         beat_nxt  = at_last ? '0 : beat_cnt + 1'b1;
         state_nxt = at_last ? S_IDLE : S_BURST;
      end else if (src_empty[grant]) begin
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= S_IDLE;
         grant    <= '0;
         last_ptr <= SW'(NUM_SRC - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         last_ptr <= last_ptr_nxt;
         beat_cnt <= beat_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed scenario bench with behavioural FWFT source FIFOs.
module tb_fifo_rr_scheduler;

   logic         clk = 1'b0;
   logic         srst = 1'b1;
   logic [3:0]   src_en = '0;
   logic [3:0]   src_empty;
   logic [127:0] src_dout;
   logic [3:0]   src_rd_en;
   logic [31:0]  m_data;
   logic [1:0]   m_src;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         m_last;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [4][1024];
   int          head [4];
   int          tail [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_src
      assign src_empty[g] = head[g] == tail[g];
      assign src_dout[g*32 +: 32] = mem[g][head[g] % 1024];
   end

   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (src_rd_en[i] && head[i] != tail[i]) head[i] <= head[i] + 1;

   fifo_rr_scheduler #(.NUM_SRC(4), .WIDTH(32), .MAX_BURST(8)) dut (
      .clk       (clk),
      .srst      (srst),
      .src_en    (src_en),
      .src_empty (src_empty),
      .src_dout  (src_dout),
      .src_rd_en (src_rd_en),
      .m_data    (m_data),
      .m_src     (m_src),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy)
   );

   function automatic logic [31:0] word(input int s, input int k);
      return 32'h5000_0000 | (32'(s) << 16) | 32'(k & 16'hFFFF);
   endfunction

   task automatic push(input int s, input logic [31:0] v);
      mem[s][tail[s] % 1024] = v;
      tail[s]++;
   endtask

   task automatic fill(input int s, input int n);
      for (int k = 0; k < n; k++) push(s, word(s, tail[s]));
   endtask

   task automatic restart();
      @(negedge clk);
      srst = 1'b1;
      m_ready = 1'b0;
      src_en = '0;
      for (int s = 0; s < 4; s++) tail[s] = head[s];
      @(negedge clk);
   endtask

   task automatic test_reset();
      int b0;
      srst = 1'b1;
      m_ready = 1'b0;
      src_en = 4'hF;
      b0 = tail[0];
      for (int s = 0; s < 4; s++) fill(s, 20);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (m_valid !== 1'b0 || src_rd_en !== 4'b0 || busy !== 1'b0 || m_last !== 1'b0 || m_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: valid=%b rd_en=%b busy=%b last=%b src=%0d, expected all zero", c, m_valid, src_rd_en, busy, m_last, m_src);
         end
      end
      @(negedge clk);
      srst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b valid=%b, expected 0 0", busy, m_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || m_valid !== 1'b1 || m_src !== 2'd0 || m_data !== word(0, b0)) begin
         errors++;
         $display("FAIL reset_first_grant: busy=%b valid=%b src=%0d data=%h, expected 1 1 0 %h", busy, m_valid, m_src, m_data, word(0, b0));
      end
   endtask

   task automatic test_single_source();
      logic [31:0] v [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      restart();
      for (int k = 0; k < 3; k++) push(2, v[k]);
      src_en = 4'hF;
      m_ready = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: busy=%b valid=%b, expected 0 0", busy, m_valid);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (m_valid !== 1'b1 || m_src !== 2'd2 || m_data !== v[k] || m_last !== 1'b0 || src_rd_en !== 4'b0100) begin
            errors++;
            $display("FAIL single_beat %0d: valid=%b src=%0d data=%h last=%b rd_en=%b, expected 1 2 %h 0 0100", k, m_valid, m_src, m_data, m_last, src_rd_en, v[k]);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0 || src_rd_en !== 4'b0) begin
         errors++;
         $display("FAIL single_drained: valid=%b rd_en=%b, expected 0 0000", m_valid, src_rd_en);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_back_idle: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_all_bursts();
      int ptr [4];
      int got, gap, bi, pos, s, exp_gap;
      restart();
      for (int i = 0; i < 4; i++) begin
         ptr[i] = tail[i];
         fill(i, 20);
      end
      src_en = 4'hF;
      m_ready = 1'b1;
      got = 0;
      gap = 0;
      @(negedge clk);
      srst = 1'b0;
      for (int c = 0; c < 300 && got < 80; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (m_valid) begin
            bi = got < 64 ? got / 8 : 8 + (got - 64) / 4;
            pos = got < 64 ? got % 8 : (got - 64) % 4;
            s = bi % 4;
            exp_gap = pos != 0 ? 0 : (bi <= 8 ? 1 : 2);
            checks++;
            if (m_src !== 2'(s) || m_data !== word(s, ptr[s])) begin
               errors++;
               $display("FAIL bursts_data beat %0d: src=%0d data=%h, expected %0d %h", got, m_src, m_data, s, word(s, ptr[s]));
            end
            checks++;
            if (m_last !== (pos == 7) || src_rd_en !== 4'(1 << s)) begin
               errors++;
               $display("FAIL bursts_ctl beat %0d: last=%b rd_en=%b, expected %b %b", got, m_last, src_rd_en, pos == 7, 4'(1 << s));
            end
            checks++;
            if (gap !== exp_gap) begin
               errors++;
               $display("FAIL bursts_gap beat %0d: gap=%0d, expected %0d", got, gap, exp_gap);
            end
            ptr[s]++;
            got++;
            gap = 0;
         end else begin
            gap++;
         end
      end
      checks++;
      if (got !== 80) begin
         errors++;
         $display("FAIL bursts_total: got=%0d, expected 80", got);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL bursts_end_idle: busy=%b valid=%b, expected 0 0", busy, m_valid);
      end
   endtask

   task automatic test_random_ready();
      int ptr [4];
      int got, bi, pos, s;
      logic pv;
      logic [31:0] pd;
      logic [1:0] ps;
      restart();
      for (int i = 0; i < 4; i++) begin
         ptr[i] = tail[i];
         fill(i, 20);
      end
      src_en = 4'hF;
      got = 0;
      pv = 1'b0;
      pd = '0;
      ps = '0;
      @(negedge clk);
      srst = 1'b0;
      for (int c = 0; c < 3000 && got < 80; c++) begin
         if (c > 0) @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         #1;
         if (pv) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== pd || m_src !== ps) begin
               errors++;
               $display("FAIL rand_hold cyc %0d: valid=%b data=%h src=%0d, expected 1 %h %0d", c, m_valid, m_data, m_src, pd, ps);
            end
         end
         checks++;
         if (src_rd_en !== ((m_valid && m_ready) ? 4'(1 << m_src) : 4'b0)) begin
            errors++;
            $display("FAIL rand_rd_en cyc %0d: rd_en=%b valid=%b ready=%b src=%0d", c, src_rd_en, m_valid, m_ready, m_src);
         end
         if (m_valid && m_ready) begin
            bi = got < 64 ? got / 8 : 8 + (got - 64) / 4;
            pos = got < 64 ? got % 8 : (got - 64) % 4;
            s = bi % 4;
            checks++;
            if (m_src !== 2'(s) || m_data !== word(s, ptr[s]) || m_last !== (pos == 7)) begin
               errors++;
               $display("FAIL rand_scoreboard beat %0d: src=%0d data=%h last=%b, expected %0d %h %b", got, m_src, m_data, m_last, s, word(s, ptr[s]), pos == 7);
            end
            ptr[s]++;
            got++;
         end
         pv = m_valid && !m_ready;
         pd = m_data;
         ps = m_src;
      end
      checks++;
      if (got !== 80) begin
         errors++;
         $display("FAIL rand_total: got=%0d, expected 80", got);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_en_mask();
      int bsrc [5] = '{-1, -1, -1, -1, -1};
      int blen [5] = '{0, 0, 0, 0, 0};
      int exp_src [5] = '{0, 1, 3, 0, 3};
      int nb, beats;
      logic cleared;
      restart();
      for (int i = 0; i < 4; i++) fill(i, 16);
      src_en = 4'b1011;
      m_ready = 1'b1;
      nb = 0;
      beats = 0;
      cleared = 1'b0;
      @(negedge clk);
      srst = 1'b0;
      for (int c = 0; c < 200 && nb < 5; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (m_valid) begin
            checks++;
            if (m_src === 2'd2) begin
               errors++;
               $display("FAIL en_mask_src2 cyc %0d: src=%0d, expected not 2", c, m_src);
            end
            beats++;
            if (m_src === 2'd1 && !cleared) begin
               src_en = 4'b1001;
               cleared = 1'b1;
            end
            if (m_last) begin
               bsrc[nb] = int'(m_src);
               blen[nb] = beats;
               nb++;
               beats = 0;
            end
         end
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bsrc[k] !== exp_src[k] || blen[k] !== 8) begin
            errors++;
            $display("FAIL en_mask_burst %0d: src=%0d len=%0d, expected %0d 8", k, bsrc[k], blen[k], exp_src[k]);
         end
      end
   endtask

   task automatic test_srst_mid_burst();
      int b0, b1;
      restart();
      b0 = tail[0];
      b1 = tail[1];
      fill(0, 8);
      fill(1, 8);
      fill(2, 4);
      src_en = 4'b0010;
      m_ready = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== word(1, b1 + k)) begin
            errors++;
            $display("FAIL mid_beat %0d: valid=%b src=%0d data=%h, expected 1 1 %h", k, m_valid, m_src, m_data, word(1, b1 + k));
         end
      end
      @(negedge clk);
      srst = 1'b1;
      #1;
      checks++;
      if (src_rd_en !== 4'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_src !== 2'd0) begin
         errors++;
         $display("FAIL mid_srst_gate: rd_en=%b valid=%b busy=%b src=%0d, expected 0000 0 0 0", src_rd_en, m_valid, busy, m_src);
      end
      @(negedge clk);
      checks++;
      if (tail[1] - head[1] !== 5) begin
         errors++;
         $display("FAIL mid_retained: src1 holds %0d, expected 5", tail[1] - head[1]);
      end
      srst = 1'b0;
      src_en = 4'hF;
      #1;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_idle: busy=%b valid=%b, expected 0 0", busy, m_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_src !== 2'd0 || m_data !== word(0, b0)) begin
         errors++;
         $display("FAIL mid_regrant: valid=%b src=%0d data=%h, expected 1 0 %h", m_valid, m_src, m_data, word(0, b0));
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_all_bursts();
      test_random_ready();
      test_en_mask();
      test_srst_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
